fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage core.
//  Owns the PC and drives the 1-cycle-latency synchronous instruction memory.
//  Presents {pc, instruction, valid} to decode; ifid_opcode (insn[31:27]) feeds decode_op_code directly.
//  Honours stall from the hazard unit and redirect (branch/jump) from execute; a redirect inserts a bubble.
// PARAMETERS
//  PC_W      32  PC width; word-addressed, increments by 1 per instruction
//  IMEM_AW   12  instruction memory address width; imem_addr = pc_next[IMEM_AW-1:0]
//  RESET_PC  0   PC value loaded on reset
//  CNT_W     32  width of retired-fetch counter
// PORTS
//  clock            in   1        rising-edge clock
//  reset_n          in   1        asynchronous, active-low reset
//  imem_addr        out  IMEM_AW  address presented to imem; memory registers it on clock edge
//  imem_q           in   32       instruction word for the address latched on the previous edge
//  stall            in   1        hold PC and IF/ID (load-use hazard)
//  redirect         in   1        take redirect_target; flush IF/ID
//  redirect_target  in   PC_W     new PC on redirect
//  ifid_valid       out  1        IF/ID holds a real instruction
//  ifid_pc          out  PC_W     PC of instruction in IF/ID
//  ifid_insn        out  32       instruction in IF/ID (NOP = 32'h0 when invalid)
//  ifid_opcode      out  5        ifid_insn[31:27], combinational slice
//  fetch_count      out  CNT_W    number of instructions loaded valid into IF/ID
// BEHAVIOUR
//  Reset (async, any time incl. mid-operation): pc_f=RESET_PC, state=BOOT, ifid_valid=0,
//   ifid_pc=0, ifid_insn=0, fetch_count=0. Effective immediately, not at next edge.
//  FSM: BOOT -> RUN after exactly one clock; no other transitions except reset -> BOOT.
//   BOOT: imem_q not yet valid; pc_next=pc_f; IF/ID stays invalid; stall ignored.
//         redirect in BOOT: pc_f<=redirect_target, still go to RUN, IF/ID stays invalid.
//   RUN: imem_q is the instruction at pc_f.
//  pc_next (combinational, RUN), priority high->low:
//   redirect -> redirect_target; stall -> pc_f; else -> pc_f+1 (mod 2^PC_W, FFFF_FFFF->0).
//  imem_addr = pc_next[IMEM_AW-1:0] always, so memory re-reads pc_f during stall.
//  pc_f <= pc_next every edge.
//  IF/ID update (RUN):
//   redirect (with or without stall): ifid_valid<=0, ifid_insn<=0, ifid_pc<=0 (bubble).
//   stall, no redirect: hold all IF/ID outputs.
//   else: ifid_valid<=1, ifid_insn<=imem_q, ifid_pc<=pc_f; fetch_count<=fetch_count+1.
//  Latency: insn at PC p appears in IF/ID 1 cycle after pc_f==p with no stall.
//  First valid IF/ID: 2nd edge after reset deassert (BOOT edge, then RUN edge).
//  Redirect penalty: 1 bubble; target insn in IF/ID 2 edges after redirect edge.
//  fetch_count wraps modulo 2^CNT_W; never counts bubbles or held cycles.
//  Inputs stall/redirect sampled only on the edge; no combinational path from them to ifid_*.
// STRUCTURE
//  Shared package/include: opcode constants (ALU=00000, ADDI=00101, SW=00111, LW=01000),
//   NOP encoding 32'h0, state encodings BOOT/RUN, default PC_W/IMEM_AW.
//  One sub-module natural: pc_next_sel (combinational priority mux redirect>stall>inc).
//  Rest (pc_f, FSM, IF/ID regs, counter) in fetch_stage.
// TESTING
//  Reset release, imem[0..3]=A,B,C,D, no stall -> edge1 valid=0; edges2..5 ifid_insn=A,B,C,D, pc=0..3, fetch_count=4.
//  Stall held 3 cycles while IF/ID=B(pc1) -> IF/ID stays B, imem_addr stays 2, count frozen; release -> C then D.
//  Redirect to 0x40 while IF/ID=B -> next edge valid=0, insn=0; following edge insn=imem[0x40], pc=0x40.
//  Redirect and stall same cycle -> redirect wins: bubble inserted, pc_f=target, no hold.
//  Force pc_f=FFFF_FFFF via redirect, run -> next pc 0, imem_addr 0, ifid_pc FFFF_FFFF then 0.
//  Assert reset_n=0 mid-stream between edges -> outputs clear immediately; on release BOOT then RUN, first insn from RESET_PC.
//  Redirect in BOOT cycle to 0x10 -> first valid IF/ID is imem[0x10], pc=0x10.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// fetch_stage_pkg -- shared opcode constants, NOP encoding, fetch FSM states, default widths.
// Revision: 1.0
package fetch_stage_pkg;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_IMEM_AW = 12;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_next_sel.sv
`default_nettype none
// fetch_stage_pc_next_sel -- next-PC priority mux: redirect > (stall | boot hold) > increment.
// Revision: 1.0
module fetch_stage_pc_next_sel
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic [PC_W-1:0] pc_f_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            stall_i,
  input  logic            boot_i,
  output logic [PC_W-1:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_f_i + PC_W'(1);
    if (redirect_i) begin
      pc_next_o = target_i;
    end else if (stall_i || boot_i) begin
      pc_next_o = pc_f_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage -- owns the PC, drives the synchronous instruction memory, holds the IF/ID register.
// Revision: 1.0
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              IMEM_AW  = DEF_IMEM_AW,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               ifid_valid,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [31:0]        ifid_insn,
  output logic [4:0]         ifid_opcode,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_f_q;
  logic [PC_W-1:0]   pc_next;
  logic              valid_q, valid_d;
  logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]       insn_q, insn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  fetch_stage_pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .pc_f_i     (pc_f_q),
    .redirect_i (redirect),
    .target_i   (redirect_target),
    .stall_i    (stall),
    .boot_i     (state_q == ST_BOOT),
    .pc_next_o  (pc_next)
  );

  // The memory re-reads pc_f while stalled because pc_next holds it.
  assign imem_addr = pc_next[IMEM_AW-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BOOT;
      pc_f_q    <= RESET_PC;
      valid_q   <= 1'b0;
      ifid_pc_q <= '0;
      insn_q    <= NOP_INSN;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_next;
      valid_q   <= valid_d;
      ifid_pc_q <= ifid_pc_d;
      insn_q    <= insn_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = ST_RUN;
    valid_d   = valid_q;
    ifid_pc_d = ifid_pc_q;
    insn_d    = insn_q;
    cnt_d     = cnt_q;
    if (state_q == ST_RUN) begin
      if (redirect) begin
        valid_d   = 1'b0;
        ifid_pc_d = '0;
        insn_d    = NOP_INSN;
      end else if (!stall) begin
        valid_d   = 1'b1;
        ifid_pc_d = pc_f_q;
        insn_d    = imem_q;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  assign ifid_valid  = valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_insn   = insn_q;
  assign ifid_opcode = insn_q[31:27];
  assign fetch_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage -- scoreboard bench for fetch_stage against an instruction-stream reference model.
// Revision: 1.0
module tb_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic [11:0] imem_addr;
  logic [31:0] imem_q;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_insn;
  logic [4:0]  ifid_opcode;
  logic [31:0] fetch_count;

  fetch_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_q          (imem_q),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_insn       (ifid_insn),
    .ifid_opcode     (ifid_opcode),
    .fetch_count     (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:4095];
  always @(posedge clock) imem_q <= mem[imem_addr];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the stream of fetched instructions, described by PC and memory contents.
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_valid;
  logic [31:0] m_pcid;
  logic [31:0] m_insn;
  logic [31:0] m_cnt;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1'b1; m_valid = 1'b0;
    m_pcid = 32'h0; m_insn = 32'h0; m_cnt = 32'h0;
  endtask

  // Starts and ends at a negedge; one clock edge is driven and predicted.
  task automatic cycle(input logic s, input logic r, input logic [31:0] tgt);
    logic [31:0] nxt;
    exp_t e;
    stall = s; redirect = r; redirect_target = tgt;
    if (r)                nxt = tgt;
    else if (s || m_boot) nxt = m_pc;
    else                  nxt = m_pc + 32'd1;
    #1;
    check32("imem_addr", {20'h0, imem_addr}, {20'h0, nxt[11:0]});
    if (!m_boot) begin
      if (r) begin
        m_valid = 1'b0; m_pcid = 32'h0; m_insn = 32'h0;
      end else if (!s) begin
        m_valid = 1'b1; m_pcid = m_pc; m_insn = mem[m_pc[11:0]]; m_cnt = m_cnt + 32'd1;
      end
    end
    m_pc = nxt;
    m_boot = 1'b0;
    e.v = m_valid; e.pc = m_pcid; e.insn = m_insn; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.v});
      check32("ifid_pc", ifid_pc, e.pc);
      check32("ifid_insn", ifid_insn, e.insn);
      check32("ifid_opcode", {27'h0, ifid_opcode}, {27'h0, e.insn[31:27]});
      check32("fetch_count", fetch_count, e.cnt);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
    check32({tag, "_pc"}, ifid_pc, 32'h0);
    check32({tag, "_insn"}, ifid_insn, 32'h0);
    check32({tag, "_count"}, fetch_count, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'hA000_0001; mem[1] = 32'h2800_0002;
    mem[2] = 32'h3800_0003; mem[3] = 32'h4000_0004;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset_state");
    reset_n = 1'b1;

    // Straight-line fetch of A..D after reset release.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    check32("count_after_ABCD", fetch_count, 32'd4);

    // Stall while IF/ID holds B.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check32("stall_addr_held", {20'h0, imem_addr}, 32'd2);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect to 0x40 while IF/ID holds B.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect and stall together: redirect wins.
    cycle(1'b1, 1'b1, 32'h80);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0);

    // PC wrap from FFFF_FFFF to 0.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect during the BOOT cycle.
    do_reset();
    cycle(1'b0, 1'b1, 32'h10);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2)) : $urandom);
    end

    @(posedge clock);
    #2;
    check32("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
